alu_operand_fetch: RTL and testbench

//   Operand-fetch stage directly upstream of the 32-bit ALU (3-bit selector, out/carry/overflow/zero).

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_operand_fetch_regfile_2r1w.sv | 52 +++++
 rtl/alu_operand_fetch.sv | 124 ++++++++++++
 tb/tb_alu_operand_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU selector encodings and datapath width defaults.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_NREGS = 32;
    localparam int ALU_AW    = 5;

    typedef logic [2:0] alu_sel_t;

    localparam alu_sel_t ALU_ADD  = 3'b000;
    localparam alu_sel_t ALU_SUB  = 3'b001;
    localparam alu_sel_t ALU_XOR  = 3'b010;
    localparam alu_sel_t ALU_SLT  = 3'b011;
    localparam alu_sel_t ALU_AND  = 3'b100;
    localparam alu_sel_t ALU_NAND = 3'b101;
    localparam alu_sel_t ALU_NOR  = 3'b110;
    localparam alu_sel_t ALU_OR   = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu_operand_fetch_regfile_2r1w.sv
// ============================================================================
// Module : regfile_2r1w
// Brief  : NREGS x WIDTH register file, 2 async read ports, 1 sync write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_2r1w
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int NREGS = ALU_NREGS,
    parameter int AW    = ALU_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd0_addr,
    output logic [WIDTH-1:0] rd0_data,
    input  logic [AW-1:0]    rd1_addr,
    output logic [WIDTH-1:0] rd1_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (wr_addr != '0)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd0_data = (rd0_addr == '0) ? '0 : mem_q[rd0_addr];
    assign rd1_data = (rd1_addr == '0) ? '0 : mem_q[rd1_addr];

endmodule

`default_nettype wire

// File: rtl/alu_operand_fetch.sv
// ============================================================================
// Module : alu_operand_fetch
// Brief  : Operand fetch with write-back bypass, immediate select and a
//          single-entry valid/ready register feeding the ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_fetch
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int NREGS = ALU_NREGS,
    parameter int AW    = ALU_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rs,
    input  logic [AW-1:0]    in_rt,
    input  logic             in_use_imm,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [2:0]       in_sel,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [2:0]       alu_sel
);

    logic [WIDTH-1:0] rf_rd0, rf_rd1;
    logic [WIDTH-1:0] src_a, src_b;
    logic             issue_fire, xfer_fire, wb_live;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [AW-1:0]    rs_q, rs_d, rt_q, rt_d;
    logic             use_imm_q, use_imm_d;

    regfile_2r1w #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd0_addr (in_rs),
        .rd0_data (rf_rd0),
        .rd1_addr (in_rt),
        .rd1_data (rf_rd1),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data)
    );

    assign in_ready   = !out_valid_q || out_ready;
    assign issue_fire = in_valid && in_ready;
    assign xfer_fire  = out_valid_q && out_ready;
    assign wb_live    = wb_en && (wb_addr != '0);

    // Write-first bypass: a same-cycle write-back wins over the stored value.
    always_comb begin
        src_a = rf_rd0;
        if (in_rs == '0)                    src_a = '0;
        else if (wb_en && wb_addr == in_rs) src_a = wb_data;
        src_b = rf_rd1;
        if (in_rt == '0)                    src_b = '0;
        else if (wb_en && wb_addr == in_rt) src_b = wb_data;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        alu_sel_d   = alu_sel_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        use_imm_d   = use_imm_q;
        if (issue_fire) begin
            out_valid_d = 1'b1;
            op_a_d      = src_a;
            op_b_d      = in_use_imm ? in_imm : src_b;
            alu_sel_d   = in_sel;
            rs_d        = in_rs;
            rt_d        = in_rt;
            use_imm_d   = in_use_imm;
        end else if (xfer_fire) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            // Stalled entry tracks later writes to its source registers.
            if (wb_live && wb_addr == rs_q)               op_a_d = wb_data;
            if (wb_live && wb_addr == rt_q && !use_imm_q) op_b_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            alu_sel_q   <= ALU_ADD;
            rs_q        <= '0;
            rt_q        <= '0;
            use_imm_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            alu_sel_q   <= alu_sel_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            use_imm_q   <= use_imm_d;
        end
    end

    assign out_valid = out_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign alu_sel   = alu_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_fetch.sv
// ============================================================================
// Module : tb_alu_operand_fetch
// Brief  : Directed self-checking bench for alu_operand_fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_use_imm, wb_en, out_valid, out_ready;
    logic [4:0]  in_rs, in_rt, wb_addr;
    logic [31:0] in_imm, wb_data, op_a, op_b;
    logic [2:0]  in_sel, alu_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_operand_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .in_sel     (in_sel),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_sel    (alu_sel)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [4:0] rs, input logic [4:0] rt, input logic ui,
                             input logic [31:0] imm, input logic [2:0] sel);
        in_valid = 1'b1; in_rs = rs; in_rt = rt; in_use_imm = ui; in_imm = imm; in_sel = sel;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_rs = '0; in_rt = '0; in_use_imm = 1'b0;
        in_imm = '0; in_sel = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("FAIL reset_ops got %h %h exp 0 0", op_a, op_b); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (alu_sel !== 3'b000) begin errors++; $display("FAIL reset_sel got %b exp 000", alu_sel); end
        step(); step();
        rst_n = 1'b1;
        step();
        set_issue(5'd5, 5'd6, 1'b0, 32'h0, 3'b000);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || op_a !== 32'h0 || op_b !== 32'h0) begin
            errors++; $display("FAIL reset_first_issue got v=%b %h %h exp 1 0 0", out_valid, op_a, op_b); end
        step();
    endtask

    task automatic test_basic();
        write_reg(5'd3, 32'h0000000A);
        write_reg(5'd4, 32'h00000003);
        set_issue(5'd3, 5'd4, 1'b0, 32'h0, 3'b001);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || op_a !== 32'hA || op_b !== 32'h3 || alu_sel !== 3'b001) begin
            errors++; $display("FAIL basic got v=%b a=%h b=%h s=%b exp 1 a b 001", out_valid, op_a, op_b, alu_sel); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h12345678;
        set_issue(5'd7, 5'd7, 1'b0, 32'h0, 3'b010);
        step();
        wb_en = 1'b0; in_valid = 1'b0;
        checks++; if (op_a !== 32'h12345678 || op_b !== 32'h12345678 || alu_sel !== 3'b010) begin
            errors++; $display("FAIL bypass got a=%h b=%h s=%b exp 12345678 12345678 010", op_a, op_b, alu_sel); end
        step();
        set_issue(5'd7, 5'd3, 1'b0, 32'h0, 3'b011);
        step();
        in_valid = 1'b0;
        checks++; if (op_a !== 32'h12345678 || op_b !== 32'hA) begin
            errors++; $display("FAIL bypass_stored got a=%h b=%h exp 12345678 0000000a", op_a, op_b); end
        step();
    endtask

    task automatic test_r0_imm();
        write_reg(5'd0, 32'hFFFFFFFF);
        set_issue(5'd0, 5'd4, 1'b1, 32'h80000000, 3'b100);
        step();
        in_valid = 1'b0;
        checks++; if (op_a !== 32'h0 || op_b !== 32'h80000000 || alu_sel !== 3'b100) begin
            errors++; $display("FAIL r0_imm got a=%h b=%h s=%b exp 0 80000000 100", op_a, op_b, alu_sel); end
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h55555555;
        set_issue(5'd0, 5'd0, 1'b0, 32'h0, 3'b111);
        step();
        wb_en = 1'b0; in_valid = 1'b0;
        checks++; if (op_a !== 32'h0 || op_b !== 32'h0) begin
            errors++; $display("FAIL r0_bypass got a=%h b=%h exp 0 0", op_a, op_b); end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_a;
        write_reg(5'd9, 32'h00001111);
        write_reg(5'd10, 32'h00002222);
        out_ready = 1'b0;
        set_issue(5'd9, 5'd10, 1'b0, 32'h0, 3'b010);
        step();
        set_issue(5'd3, 5'd4, 1'b0, 32'h0, 3'b000);
        exp_a = 32'h00001111;
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || op_a !== exp_a ||
                          op_b !== 32'h00002222 || alu_sel !== 3'b010) begin
                errors++; $display("FAIL stall_hold c=%0d got v=%b r=%b a=%h b=%h s=%b exp 1 0 %h 00002222 010",
                                   c, out_valid, in_ready, op_a, op_b, alu_sel, exp_a); end
            if (c == 1) begin wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEADBEEF; end
            step();
            wb_en = 1'b0;
            if (c == 1) exp_a = 32'hDEADBEEF;
        end
        checks++; if (op_a !== 32'hDEADBEEF || op_b !== 32'h00002222) begin
            errors++; $display("FAIL stall_coherent got a=%h b=%h exp deadbeef 00002222", op_a, op_b); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flow_ready got %b exp 1", in_ready); end
        step();
        set_issue(5'd4, 5'd3, 1'b0, 32'h0, 3'b110);
        checks++; if (out_valid !== 1'b1 || op_a !== 32'hA || op_b !== 32'h3 || alu_sel !== 3'b000) begin
            errors++; $display("FAIL stream1 got v=%b a=%h b=%h s=%b exp 1 a 3 000", out_valid, op_a, op_b, alu_sel); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || op_a !== 32'h3 || op_b !== 32'hA || alu_sel !== 3'b110) begin
            errors++; $display("FAIL stream2 got v=%b a=%h b=%h s=%b exp 1 3 a 110", out_valid, op_a, op_b, alu_sel); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_coherency_same_reg();
        out_ready = 1'b0;
        set_issue(5'd11, 5'd11, 1'b0, 32'h0, 3'b101);
        step();
        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'hCAFEF00D;
        step();
        wb_en = 1'b0;
        checks++; if (op_a !== 32'hCAFEF00D || op_b !== 32'hCAFEF00D) begin
            errors++; $display("FAIL coh_rs_eq_rt got a=%h b=%h exp cafef00d cafef00d", op_a, op_b); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        set_issue(5'd12, 5'd11, 1'b1, 32'h00000042, 3'b000);
        step();
        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'h99999999;
        step();
        wb_en = 1'b0;
        checks++; if (op_a !== 32'h0 || op_b !== 32'h00000042) begin
            errors++; $display("FAIL coh_imm_keep got a=%h b=%h exp 0 42", op_a, op_b); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        set_issue(5'd3, 5'd9, 1'b0, 32'h0, 3'b111);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_stall_setup got %b exp 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || op_a !== 32'h0 || op_b !== 32'h0 || alu_sel !== 3'b000) begin
            errors++; $display("FAIL async_reset got v=%b a=%h b=%h s=%b exp 0 0 0 000", out_valid, op_a, op_b, alu_sel); end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        set_issue(5'd3, 5'd9, 1'b0, 32'h0, 3'b000);
        step();
        set_issue(5'd7, 5'd11, 1'b0, 32'h0, 3'b000);
        checks++; if (op_a !== 32'h0 || op_b !== 32'h0) begin
            errors++; $display("FAIL rf_cleared_1 got a=%h b=%h exp 0 0", op_a, op_b); end
        step();
        in_valid = 1'b0;
        checks++; if (op_a !== 32'h0 || op_b !== 32'h0) begin
            errors++; $display("FAIL rf_cleared_2 got a=%h b=%h exp 0 0", op_a, op_b); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_r0_imm();
        test_backpressure();
        test_coherency_same_reg();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
